// File: rtl/conv_pkg.sv
// conv_pkg: shared state type and arithmetic helpers for the conv2d stream engine
package conv_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  function automatic int acc_width(input int dw, input int ww, input int k);
    return dw + ww + $clog2(k * k) + 1;
  endfunction
  function automatic int stride_fix(input int s, input int smax);
    return (s == 0 || s > smax) ? 1 : s;
  endfunction
  // Arithmetic shift (toward -inf) then clamp to a signed ow-bit range.
  function automatic logic signed [63:0] shift_sat(input logic signed [63:0] v, input logic [5:0] sh, input int ow);
    logic signed [63:0] t, hi, lo;
    t = v >>> sh;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    return t > hi ? hi : t < lo ? lo : t;
  endfunction
endpackage

// File: rtl/conv_mac_cell.sv
// conv_mac_cell: registered signed multiply-accumulate, y <= a*b + c when en
//   clk, rst (async, active-high), en: advance; a: activation; b: weight; c: incoming partial; y: outgoing partial
module conv_mac_cell #(
  parameter int AW = 16,
  parameter int BW = 16,
  parameter int CW = 37
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  input  logic signed [CW-1:0] c,
  output logic signed [CW-1:0] y
);
  always_ff @(posedge clk or posedge rst)
    if (rst) y <= '0;
    else if (en) y <= CW'(a) * CW'(b) + c;
endmodule

// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: streaming KxK convolution with stride, bias, shift and saturation
//   start/cfg_stride/cfg_shift: begin a map; w_valid/w_ready/w_data: K*K weights then bias
//   in_valid/in_ready/in_data: raster pixels; out_valid/out_ready/out_data/out_last: results; busy: not IDLE
module conv2d_stream_engine import conv_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int WGT_W = 16,
  parameter int OUT_W = 16,
  parameter int FM_ROW = 10,
  parameter int FM_COL = 10,
  parameter int K = 3,
  parameter int S_MAX = 4,
  localparam int ACC_W = acc_width(DATA_W, WGT_W, K),
  localparam int SW = $clog2(S_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SW-1:0]            cfg_stride,
  input  logic [5:0]               cfg_shift,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic signed [WGT_W-1:0]  w_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     busy
);
  localparam int KK = K * K;
  localparam int LB = FM_COL - K;
  localparam int RW = $clog2(FM_ROW);
  localparam int CW = $clog2(FM_COL);
  localparam int WC = $clog2(KK + 1);
  state_t state;
  logic [SW-1:0] stride, rph, cph, rph_n, cph_n;
  logic [5:0] shift;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [WC-1:0] wcnt;
  logic done, px, emit, last, c_end, r_end;
  logic signed [WGT_W-1:0] w [KK];
  logic signed [ACC_W-1:0] bias;
  logic signed [ACC_W-1:0] y [KK];
  logic signed [ACC_W-1:0] cin [KK];
  assign w_ready = state == LOAD;
  assign busy = state != IDLE;
  assign in_ready = state == RUN && !done && (!out_valid || out_ready);
  assign px = in_valid && in_ready;
  assign c_end = int'(c) == FM_COL - 1;
  assign r_end = int'(r) == FM_ROW - 1;
  // rph/cph hold (r-K+1)%S and (c-K+1)%S for the current pixel; zero before the first full window
  assign cph_n = (c_end || int'(c) + 1 <= K - 1 || cph == stride - 1'b1) ? '0 : cph + 1'b1;
  assign rph_n = (r_end || int'(r) + 1 <= K - 1 || rph == stride - 1'b1) ? '0 : rph + 1'b1;
  assign emit = int'(r) >= K - 1 && int'(c) >= K - 1 && rph == '0 && cph == '0;
  // No further emitting window fits to the right or below: this is the map's final result
  assign last = int'(r) + int'(stride) >= FM_ROW && int'(c) + int'(stride) >= FM_COL;
  // The last cell's register doubles as the output data register; it only moves on an accepted pixel,
  // and pixels are refused while a result is stalled, so out_data holds under backpressure
  assign out_data = OUT_W'(shift_sat(64'(y[KK - 1]), shift, OUT_W));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      stride <= '0;
      shift <= '0;
      r <= '0;
      c <= '0;
      rph <= '0;
      cph <= '0;
      wcnt <= '0;
      done <= 1'b0;
      w <= '{default: '0};
      bias <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        state <= LOAD;
        stride <= SW'(stride_fix(int'(cfg_stride), S_MAX));
        shift <= cfg_shift;
        wcnt <= '0;
      end
      if (state == LOAD && w_valid) begin
        if (int'(wcnt) == KK) begin
          bias <= ACC_W'(w_data);
          state <= RUN;
          r <= '0;
          c <= '0;
          rph <= '0;
          cph <= '0;
          done <= 1'b0;
        end else begin
          for (int m = 0; m < KK - 1; m++) w[m] <= w[m + 1];
          w[KK - 1] <= w_data;
          wcnt <= wcnt + 1'b1;
        end
      end
      if (out_ready) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
      if (px) begin
        c <= c_end ? '0 : c + 1'b1;
        cph <= cph_n;
        if (c_end) begin
          r <= r_end ? '0 : r + 1'b1;
          rph <= rph_n;
        end
        if (c_end && r_end) done <= 1'b1;
        if (emit) begin
          out_valid <= 1'b1;
          out_last <= last;
        end
      end
      if (state == RUN && done && (!out_valid || out_ready)) state <= IDLE;
    end
  // Transposed systolic chain: every cell sees the current pixel; partials flow w[0]..w[KK-1],
  // with a line delay after each kernel row so the next row meets pixels one map row later
  for (genvar i = 0; i < K; i++) begin : g_row
    for (genvar j = 0; j < K; j++) begin : g_col
      localparam int N = i * K + j;
      if (N == 0) begin : g_bias
        assign cin[N] = bias;
      end else if (j > 0 || LB == 0) begin : g_chain
        assign cin[N] = y[N - 1];
      end else begin : g_line
        logic signed [ACC_W-1:0] sr [LB];
        always_ff @(posedge clk or posedge rst)
          if (rst) sr <= '{default: '0};
          else if (px) begin
            sr[0] <= y[N - 1];
            for (int m = 1; m < LB; m++) sr[m] <= sr[m - 1];
          end
        assign cin[N] = sr[LB - 1];
      end
      conv_mac_cell #(.AW(DATA_W), .BW(WGT_W), .CW(ACC_W)) u_mac (
        .clk(clk),
        .rst(rst),
        .en(px),
        .a(in_data),
        .b(w[N]),
        .c(cin[N]),
        .y(y[N])
      );
    end
  end
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// tb_conv2d_stream_engine: scoreboard bench for conv2d_stream_engine
module tb_conv2d_stream_engine;
  localparam int ROW = 10;
  localparam int COL = 10;
  localparam int K = 3;
  logic clk = 1'b0;
  logic rst, start, w_valid, w_ready, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [2:0] cfg_stride;
  logic [5:0] cfg_shift;
  logic signed [15:0] w_data, in_data, out_data;
  longint exp_q[$];
  bit last_q[$];
  int wt[K*K];
  int img[ROW*COL];
  bit emit_px[ROW*COL];
  longint bias_v;
  int shift_v, bp, nout, stuck, n_chk, n_pass, pend_e;
  bit pend, stall, sl;
  logic signed [15:0] sd;

  always #5 clk = ~clk;

  conv2d_stream_engine dut (
    .clk(clk), .rst(rst), .start(start), .cfg_stride(cfg_stride), .cfg_shift(cfg_shift),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  initial forever begin
    @(posedge clk);
    #1 out_ready = ($urandom_range(99) >= bp);
  end

  initial forever begin
    @(negedge clk);
    if (rst) stall = 0;
    else begin
      if (stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, sd);
        chk("hold_last", out_last, sl);
      end
      stall = out_valid && !out_ready;
      sd = out_data;
      sl = out_last;
      if (stall) chk("bp_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        nout++;
        chk("q_has_item", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("out_data", out_data, exp_q.pop_front());
          chk("out_last", out_last, last_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  task automatic expect_map(input int s);
    longint acc, v;
    for (int p = 0; p < ROW * COL; p++) emit_px[p] = 0;
    for (int r = K - 1; r < ROW; r += s)
      for (int c = K - 1; c < COL; c += s) begin
        acc = bias_v;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            acc += longint'(wt[i*K+j]) * img[(r-K+1+i)*COL + c-K+1+j];
        v = acc >>> shift_v;
        v = v > 32767 ? 32767 : v < -32768 ? -32768 : v;
        exp_q.push_back(v);
        last_q.push_back(r + s >= ROW && c + s >= COL);
        emit_px[r*COL+c] = 1;
      end
  endtask

  task automatic lat();
    if (pend) chk("latency", out_valid, pend_e);
    pend = 0;
  endtask

  task automatic load(input logic [2:0] s, input logic [5:0] sh);
    start = 1;
    cfg_stride = s;
    cfg_shift = sh;
    @(posedge clk); #1;
    start = 0;
    chk("load_busy", busy, 1);
    chk("load_w_ready", w_ready, 1);
    for (int i = 0; i <= K * K; i++) begin
      w_valid = 1;
      w_data = i < K * K ? 16'(wt[i]) : 16'(bias_v);
      @(posedge clk); #1;
    end
    w_valid = 0;
    chk("run_in_ready", in_ready, 1);
  endtask

  task automatic feed(input int n, input int gap);
    int t;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap) begin
        in_valid = 0;
        @(negedge clk); lat();
        @(posedge clk); #1;
      end
      in_valid = 1;
      in_data = 16'(img[i]);
      t = 0;
      @(negedge clk); lat();
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t == 200) stuck++;
      @(posedge clk); #1;
      pend = (bp == 0);
      pend_e = emit_px[i];
    end
    in_valid = 0;
    @(negedge clk); lat();
  endtask

  task automatic run_map(input logic [2:0] cs, input int sh, input int gap, input int bpp, input bit poke);
    int s, t;
    s = (cs == 0 || cs > 4) ? 1 : int'(cs);
    shift_v = sh;
    bp = bpp;
    nout = 0;
    stuck = 0;
    expect_map(s);
    load(cs, 6'(sh));
    if (poke) begin
      start = 1;
      cfg_stride = 3'd2;
      cfg_shift = 6'd5;
      w_valid = 1;
      w_data = 16'h1234;
      @(negedge clk);
      chk("poke_w_ready", w_ready, 0);
      chk("poke_busy", busy, 1);
      @(posedge clk); #1;
      start = 0;
      w_valid = 0;
    end
    feed(ROW * COL, gap);
    chk("stuck", stuck, 0);
    chk("done_in_ready", in_ready, 0);
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_q", exp_q.size(), 0);
    chk("end_busy", busy, 0);
    chk("n_out", nout, ((ROW - K) / s + 1) * ((COL - K) / s + 1));
    bp = 0;
    @(posedge clk); #1;
  endtask

  task automatic set_w(input int v);
    for (int i = 0; i < K * K; i++) wt[i] = v;
  endtask

  task automatic set_img_seq();
    for (int i = 0; i < ROW * COL; i++) img[i] = i + 1;
  endtask

  task automatic set_img_const(input int v);
    for (int i = 0; i < ROW * COL; i++) img[i] = v;
  endtask

  initial begin
    rst = 1; start = 0; cfg_stride = 0; cfg_shift = 0; w_valid = 0; w_data = 0;
    in_valid = 0; in_data = 0; out_ready = 1; bp = 0; pend = 0; stall = 0;
    n_chk = 0; n_pass = 0; nout = 0; stuck = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 0;
    @(posedge clk); #1;
    set_w(1); bias_v = 0; set_img_seq();
    run_map(3'd1, 0, 0, 0, 0);
    run_map(3'd2, 0, 0, 0, 0);
    set_w(32767); set_img_const(32767);
    run_map(3'd4, 0, 0, 0, 0);
    set_w(-32768);
    run_map(3'd4, 0, 0, 0, 0);
    set_w(0); wt[0] = 1; bias_v = -4; set_img_const(1);
    run_map(3'd1, 2, 0, 0, 0);
    for (int i = 0; i < K * K; i++) wt[i] = int'($urandom_range(40)) - 20;
    for (int i = 0; i < ROW * COL; i++) img[i] = int'($urandom_range(2000)) - 1000;
    bias_v = longint'($urandom_range(10000)) - 5000;
    run_map(3'd3, 1, 30, 20, 0);
    set_w(1); bias_v = 0; set_img_seq();
    run_map(3'd1, 0, 50, 30, 0);
    shift_v = 0; bp = 0; nout = 0; stuck = 0;
    expect_map(1);
    load(3'd1, 6'd0);
    feed(37, 0);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_w_ready", w_ready, 0);
    exp_q.delete();
    last_q.delete();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    run_map(3'd1, 0, 20, 0, 0);
    run_map(3'd0, 0, 0, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
